uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, 8N1 (8 data bits, no parity, 1 stop bit).
//  Generates its own OVERSAMPLE x baud tick and samples each bit at its centre.
//  Validates the start bit and stop bit. Delivers one byte per frame as a 1-cycle valid pulse.
//  Sits between the board RX pin and the byte-level consumer; pairs with the team's baud_gen-driven transmitter.
// PARAMETERS
//  CLK_FREQ    100000000  system clock frequency, Hz
//  BAUD_RATE   115200     serial bit rate, bits/s
//  OVERSAMPLE  16         sample ticks per bit; even, >=4
//  Derived: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer floor. DIV<1 -> $fatal at elaboration.
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset: synchronous, active-high
//  rx_i         in   1  serial input, asynchronous to clk, idle high
//  data_o       out  8  last correctly received byte
//  valid_o      out  1  1-cycle pulse: data_o updated this cycle
//  frame_err_o  out  1  1-cycle pulse: stop bit sampled low
//  busy_o       out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset, applied on posedge clk while rst=1:
//   - state=IDLE; data_o=0; valid_o=0; frame_err_o=0; busy_o=0.
//   - Both synchroniser flops=1; tick counter=0; sample/bit counters=0.
//  Reset mid-frame abandons the frame: no valid_o and no frame_err_o for it.
//  Sync: rx_i -> 2-flop synchroniser -> rx_s. All decisions use rx_s only.
//  Tick: counter 0..DIV-1, free-running from reset. tick=1 for one clk when count==DIV-1.
//  FSM states: IDLE, START, DATA, STOP, BREAK. Counters advance only on tick.
//   IDLE : on a tick with rx_s==0 -> START, scnt=0.
//   START: at scnt==OVERSAMPLE/2-1 (mid start bit):
//          rx_s==0 -> DATA, scnt=0, bit=0.
//          rx_s==1 -> IDLE (glitch rejected, no outputs).
//   DATA : at scnt==OVERSAMPLE-1:
//          shift rx_s into shreg MSB; shift right (LSB first on the wire); scnt=0.
//          After bit==7 -> STOP.
//   STOP : at scnt==OVERSAMPLE-1:
//          rx_s==1 -> data_o<=shreg, valid_o pulse, go to IDLE.
//          rx_s==0 -> frame_err_o pulse, data_o unchanged, go to BREAK.
//   BREAK: stay until a tick sees rx_s==1, then go to IDLE. No new start is accepted while rx is held low.
//  valid_o/frame_err_o are registered and assert the clk after the stop-sample tick.
//   Never both high. Never high for 2 consecutive cycles.
//  Latency, start falling edge -> valid_o: ~9.5 bit periods + 2 sync + 1 clk.
//   Start-detect jitter is <=1 tick.
//  Back-to-back frames: return to IDLE at mid stop bit gives a half-bit margin,
//   so the next start edge is caught with zero idle time.
//  Width rules:
//   - Tick counter: $clog2(DIV), min 1 bit.
//   - scnt: $clog2(OVERSAMPLE).
//   - bit counter: 3 bits.
//  No wrap-around: counters are cleared on state transitions.
// TESTING  (sim params CLK_FREQ=3200, BAUD_RATE=100, OVERSAMPLE=16 -> DIV=2, 32 clk/bit)
//  1. Send 0xA5 8N1 after 5 idle bits -> exactly one valid_o pulse, data_o=0xA5.
//     frame_err_o stays 0; busy_o high from start detect until the stop-bit sample.
//  2. Send 0x00 then 0xFF with no idle gap -> two valid_o pulses.
//     data_o=0x00 then 0xFF; no frame_err_o.
//  3. Pulse rx_i low for 10 clk (< half bit), then leave it idle -> no valid_o.
//     busy_o returns to 0 within 16 clk of the glitch.
//  4. Receive 0x11, then 0x3C with stop bit=0, rx held low 5 bits, then high 2 bits, then 0x5A:
//     - frame_err_o pulses once; data_o stays 0x11 after the error.
//     - no start is detected during the low period.
//     - valid_o then pulses with data_o=0x5A.
//  5. Assert rst for 1 clk during data bit 4 of 0xC3, then send 0x81 ->
//     - all outputs=0 after reset; no pulse from the aborted frame.
//     - next frame gives valid_o with data_o=0x81.
//  6. Sender at +3% baud, 10 consecutive random bytes -> all received correctly.
//     Zero frame_err_o pulses.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with oversampled mid-bit sampling and start/stop validation.
module uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  if (DIV < 1) begin : g_bad_div
    $fatal(1, "uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t          state, state_n;
  logic [1:0]      sync;
  logic            rx_s;
  logic [TW-1:0]   tcnt;
  logic            tick;
  logic [SW-1:0]   scnt, scnt_n;
  logic [2:0]      bitc, bitc_n;
  logic [7:0]      shreg, shreg_n, data_n;
  logic            valid_n, ferr_n;
  assign rx_s   = sync[1];
  assign tick   = tcnt == TW'(DIV - 1);
  assign busy_o = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      tcnt        <= '0;
      state       <= IDLE;
      scnt        <= '0;
      bitc        <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync        <= {sync[0], rx_i};
      tcnt        <= tick ? '0 : tcnt + 1'b1;
      state       <= state_n;
      scnt        <= scnt_n;
      bitc        <= bitc_n;
      shreg       <= shreg_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= ferr_n;
    end
  end
  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    bitc_n  = bitc;
    shreg_n = shreg;
    data_n  = data_o;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          state_n = rx_s ? IDLE : START;
          scnt_n  = '0;
        end
        START: begin
          scnt_n = scnt + 1'b1;
          if (scnt == SW'(OVERSAMPLE / 2 - 1)) begin
            state_n = rx_s ? IDLE : DATA;
            scnt_n  = '0;
            bitc_n  = '0;
          end
        end
        DATA: begin
          scnt_n = scnt + 1'b1;
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            shreg_n = {rx_s, shreg[7:1]};
            scnt_n  = '0;
            bitc_n  = bitc + 1'b1;
            state_n = bitc == 3'd7 ? STOP : DATA;
          end
        end
        STOP: begin
          scnt_n = scnt + 1'b1;
          if (scnt == SW'(OVERSAMPLE - 1)) begin
            scnt_n  = '0;
            data_n  = rx_s ? shreg : data_o;
            valid_n = rx_s;
            ferr_n  = !rx_s;
            state_n = rx_s ? IDLE : BREAK;
          end
        end
        BREAK: state_n = rx_s ? IDLE : BREAK;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 32 clk per bit.
module tb_uart_rx;
  localparam int BP = 32;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, busy_o;
  int tests = 0, fails = 0;
  int v_cnt = 0, f_cnt = 0, b_cnt = 0;
  logic pv = 1'b0, pf = 1'b0;
  logic [7:0] rxq[$];
  uart_rx #(.CLK_FREQ(3200), .BAUD_RATE(100), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(data_o),
    .valid_o(valid_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        v_cnt = v_cnt + 1;
        rxq.push_back(data_o);
      end
      if (frame_err_o) f_cnt = f_cnt + 1;
      if (busy_o) b_cnt = b_cnt + 1;
      if ((valid_o && frame_err_o) || (valid_o && pv) || (frame_err_o && pf)) begin
        fails = fails + 1;
        $display("FAIL pulse_rule valid=%b ferr=%b prev_valid=%b prev_ferr=%b", valid_o, frame_err_o, pv, pf);
      end
    end
    pv = valid_o;
    pf = frame_err_o;
  end
  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int bp);
    hold(1'b0, bp);
    for (int i = 0; i < 8; i++) hold(b[i], bp);
    hold(stop, bp);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({data_o, valid_o, frame_err_o, busy_o} !== 11'h0) begin
      fails++;
      $display("FAIL reset_outputs got data=%h v=%b f=%b b=%b want all 0", data_o, valid_o, frame_err_o, busy_o);
    end
    rst = 1'b0;
  endtask
  task automatic test_single;
    int v0, f0, b0;
    hold(1'b1, 5 * BP);
    v0 = v_cnt; f0 = f_cnt; b0 = b_cnt;
    send(8'hA5, 1'b1, BP);
    hold(1'b1, BP);
    tests++;
    if (v_cnt - v0 !== 1) begin fails++; $display("FAIL single_valid_count got %0d want 1", v_cnt - v0); end
    tests++;
    if (data_o !== 8'hA5) begin fails++; $display("FAIL single_data got %h want a5", data_o); end
    tests++;
    if (f_cnt - f0 !== 0) begin fails++; $display("FAIL single_ferr got %0d want 0", f_cnt - f0); end
    tests++;
    if (b_cnt - b0 !== 304) begin fails++; $display("FAIL single_busy_cycles got %0d want 304", b_cnt - b0); end
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL single_busy_idle got %b want 0", busy_o); end
  endtask
  task automatic test_back_to_back;
    int n0, f0;
    n0 = rxq.size(); f0 = f_cnt;
    send(8'h00, 1'b1, BP);
    send(8'hFF, 1'b1, BP);
    hold(1'b1, BP);
    tests++;
    if (rxq.size() - n0 !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", rxq.size() - n0); end
    tests++;
    if (rxq[n0] !== 8'h00) begin fails++; $display("FAIL b2b_first got %h want 00", rxq[n0]); end
    tests++;
    if (rxq[n0 + 1] !== 8'hFF) begin fails++; $display("FAIL b2b_second got %h want ff", rxq[n0 + 1]); end
    tests++;
    if (f_cnt - f0 !== 0) begin fails++; $display("FAIL b2b_ferr got %0d want 0", f_cnt - f0); end
  endtask
  task automatic test_glitch;
    int v0, b0;
    v0 = v_cnt; b0 = b_cnt;
    hold(1'b0, 10);
    hold(1'b1, 16);
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL glitch_busy got %b want 0", busy_o); end
    hold(1'b1, 2 * BP);
    tests++;
    if (b_cnt - b0 !== 16) begin fails++; $display("FAIL glitch_busy_cycles got %0d want 16", b_cnt - b0); end
    tests++;
    if (v_cnt - v0 !== 0) begin fails++; $display("FAIL glitch_valid got %0d want 0", v_cnt - v0); end
  endtask
  task automatic test_frame_err;
    int v0, f0;
    send(8'h11, 1'b1, BP);
    hold(1'b1, BP);
    v0 = v_cnt; f0 = f_cnt;
    send(8'h3C, 1'b0, BP);
    hold(1'b0, 5 * BP);
    tests++;
    if (f_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_count got %0d want 1", f_cnt - f0); end
    tests++;
    if (data_o !== 8'h11) begin fails++; $display("FAIL ferr_data_kept got %h want 11", data_o); end
    tests++;
    if (busy_o !== 1'b1) begin fails++; $display("FAIL ferr_break_busy got %b want 1", busy_o); end
    tests++;
    if (v_cnt - v0 !== 0) begin fails++; $display("FAIL ferr_no_valid got %0d want 0", v_cnt - v0); end
    hold(1'b1, 2 * BP);
    tests++;
    if (busy_o !== 1'b0) begin fails++; $display("FAIL ferr_break_exit got %b want 0", busy_o); end
    send(8'h5A, 1'b1, BP);
    hold(1'b1, BP);
    tests++;
    if (v_cnt - v0 !== 1 || data_o !== 8'h5A) begin
      fails++;
      $display("FAIL ferr_recover got valid_count=%0d data=%h want 1 5a", v_cnt - v0, data_o);
    end
    tests++;
    if (f_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_total got %0d want 1", f_cnt - f0); end
  endtask
  task automatic test_mid_reset;
    int v0, f0;
    logic [7:0] b;
    b = 8'hC3;
    hold(1'b1, 2 * BP);
    v0 = v_cnt; f0 = f_cnt;
    hold(1'b0, BP);
    for (int i = 0; i < 4; i++) hold(b[i], BP);
    hold(b[4], BP / 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({data_o, valid_o, frame_err_o, busy_o} !== 11'h0) begin
      fails++;
      $display("FAIL midrst_outputs got data=%h v=%b f=%b b=%b want all 0", data_o, valid_o, frame_err_o, busy_o);
    end
    hold(1'b1, 3 * BP);
    tests++;
    if (v_cnt - v0 !== 0 || f_cnt - f0 !== 0) begin
      fails++;
      $display("FAIL midrst_no_pulse got valid=%0d ferr=%0d want 0 0", v_cnt - v0, f_cnt - f0);
    end
    send(8'h81, 1'b1, BP);
    hold(1'b1, BP);
    tests++;
    if (v_cnt - v0 !== 1 || data_o !== 8'h81) begin
      fails++;
      $display("FAIL midrst_next got valid_count=%0d data=%h want 1 81", v_cnt - v0, data_o);
    end
  endtask
  task automatic test_fast_baud;
    logic [7:0] bytes[10];
    int n0, f0;
    n0 = rxq.size(); f0 = f_cnt;
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 10; i++) send(bytes[i], 1'b1, BP - 1);
    hold(1'b1, 2 * BP);
    tests++;
    if (rxq.size() - n0 !== 10) begin fails++; $display("FAIL fast_count got %0d want 10", rxq.size() - n0); end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (rxq[n0 + i] !== bytes[i]) begin fails++; $display("FAIL fast_byte%0d got %h want %h", i, rxq[n0 + i], bytes[i]); end
    end
    tests++;
    if (f_cnt - f0 !== 0) begin fails++; $display("FAIL fast_ferr got %0d want 0", f_cnt - f0); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_mid_reset;
    test_fast_baud;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
